mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before abort (range 2..1023).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ma_pc_plus_4_in, ma_alu_result_in, ma_write_data_in  in  32 each  from EX/MA register; alu_result is the memory address.
REQ-005 ma_rd_addr_in  in  5; ma_mem_read_in, ma_mem_write_in, ma_reg_write_in, ma_mem_to_reg_in  in  1 each.
REQ-006 dmem_req, dmem_we  out  1 each  bus request and write enable.
REQ-007 dmem_addr, dmem_wdata  out  32 each  word address and store data.
REQ-008 dmem_gnt  in  1  request accepted; dmem_rvalid  in  1  transaction complete; dmem_rdata  in  32  load data.
REQ-009 mem_stall  out  1  combinational; upstream pipeline registers hold while high.
REQ-010 wb_pc_plus_4_out, wb_alu_result_out, wb_read_data_out  out  32 each  registered, to MA/WB.
REQ-011 wb_rd_addr_out  out  5; wb_reg_write_out, wb_mem_to_reg_out  out  1 each  registered.
REQ-012 misalign_fault, bus_err  out  1 each  registered single-cycle pulses.

Function
REQ-013 mem_op = ma_mem_read_in | ma_mem_write_in; if both are high, the op is treated as a write.
REQ-014 aligned = (ma_alu_result_in[1:0] == 2'b00); only word accesses are supported.
REQ-015 FSM states: IDLE, REQ, WAIT.
REQ-016 IDLE: if mem_op && aligned, go to REQ next cycle; otherwise remain in IDLE.
REQ-017 REQ: dmem_req=1; go to WAIT on the cycle dmem_gnt=1.
REQ-018 WAIT: dmem_req=0; on dmem_rvalid=1, go to IDLE.
REQ-019 dmem_addr and dmem_wdata mirror ma_alu_result_in and ma_write_data_in in all states.
REQ-020 dmem_we = ma_mem_write_in in REQ; dmem_we=0 and dmem_req=0 in IDLE.
REQ-021 mem_stall = (IDLE & mem_op & aligned) | REQ | (WAIT & ~dmem_rvalid).
REQ-022 Non-memory op in IDLE: wb_* outputs load the inputs at the next edge; latency 1 cycle; wb_read_data_out=0.
REQ-023 Memory op: wb_* outputs load at the edge ending the dmem_rvalid cycle; wb_read_data_out=dmem_rdata for reads, 0 for writes.
REQ-024 Latency for a memory op = 1 + grant wait + response wait cycles; the new upstream op is visible on the cycle after rvalid.
REQ-025 While mem_stall=1, each edge loads a bubble: wb_reg_write_out=0, wb_mem_to_reg_out=0, other wb_* outputs=0.
REQ-026 Misaligned mem_op in IDLE: no bus request; mem_stall=0.
REQ-027 On a misaligned op, the next edge sets misalign_fault=1 for one cycle and loads a bubble.
REQ-028 Timeout counter: 10 bits; cleared in IDLE; increments each cycle in REQ or WAIT.
REQ-029 When the counter reaches TIMEOUT_CYCLES-1 without rvalid: set bus_err=1 for one cycle, load a bubble, go to IDLE, mem_stall=0 that cycle; the op is dropped.
REQ-030 dmem_gnt is ignored outside REQ; dmem_rvalid is ignored outside WAIT.
REQ-031 dmem_gnt and dmem_rvalid may both be high in REQ: go to WAIT only, and complete on the next rvalid.
REQ-032 Inputs are required stable while mem_stall=1; the block does not re-sample them.

Reset
REQ-033 rst=1 at any time forces IDLE, counter=0, dmem_req=0, and all wb_* outputs and pulse outputs = 0 immediately, including during a transaction.
REQ-034 A transaction interrupted by reset is abandoned; late dmem_gnt or dmem_rvalid after reset is ignored per REQ-030.

Verification
REQ-035 ALU op: rd=5, alu=0x10, reg_write=1 -> next edge wb_alu_result_out=0x10, wb_rd_addr_out=5, mem_stall never high.
REQ-036 Load 0x100: gnt at cycle 2, rvalid at cycle 4 with rdata=0xDEADBEEF -> mem_stall high cycles 0-3; wb_read_data_out=0xDEADBEEF, wb_mem_to_reg_out=1 after edge 4; bubbles before that.
REQ-037 Store to 0x104 with data 0xA5A5A5A5: dmem_we=1 and dmem_req=1 until gnt; wb_reg_write_out=0; completes on rvalid.
REQ-038 Load to 0x102 -> dmem_req stays 0; misalign_fault pulses one cycle; no stall.
REQ-039 TIMEOUT_CYCLES=8, gnt never asserted -> bus_err pulses after 8 cycles in REQ; FSM returns to IDLE; mem_stall drops.
REQ-040 rst asserted in WAIT, then rvalid arrives -> outputs 0, FSM in IDLE, and the rvalid has no effect.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
// Data-memory bus between the pipeline's memory-access stage and the memory.
//   dmem_req    master->slave  bus request (held until dmem_gnt)
//   dmem_we     master->slave  write enable, valid while dmem_req is high
//   dmem_addr   master->slave  word address
//   dmem_wdata  master->slave  store data
//   dmem_gnt    slave->master  request accepted
//   dmem_rvalid slave->master  transaction complete
//   dmem_rdata  slave->master  load data, valid with dmem_rvalid
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// Memory-access (MA) pipeline stage. Issues word loads/stores on a
// request/grant/rvalid bus, stalls the upstream pipeline while a transfer is
// in flight and feeds the MA/WB pipeline register.
//   clk, rst                 clock, asynchronous active-high reset
//   ma_*_in                  operation from the EX/MA register
//   bus (master)             data-memory bus (req/we/addr/wdata, gnt/rvalid/rdata)
//   mem_stall                combinational, holds the upstream registers
//   wb_*_out                 registered MA/WB outputs (bubbles while stalled)
//   misalign_fault, bus_err  registered one-cycle fault pulses
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ma_pc_plus_4_in,
  input  logic [31:0] ma_alu_result_in,
  input  logic [31:0] ma_write_data_in,
  input  logic [4:0]  ma_rd_addr_in,
  input  logic        ma_mem_read_in,
  input  logic        ma_mem_write_in,
  input  logic        ma_reg_write_in,
  input  logic        ma_mem_to_reg_in,
  mem_access_stage_if.master bus,
  output logic        mem_stall,
  output logic [31:0] wb_pc_plus_4_out,
  output logic [31:0] wb_alu_result_out,
  output logic [31:0] wb_read_data_out,
  output logic [4:0]  wb_rd_addr_out,
  output logic        wb_reg_write_out,
  output logic        wb_mem_to_reg_out,
  output logic        misalign_fault,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Counter value on the last cycle an outstanding transfer may occupy.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;

  logic        mem_op;
  logic        aligned;
  logic        is_load;
  logic        load_wb;
  logic        timeout;
  logic        fault;

  logic [31:0] wb_pc_plus_4_d, wb_alu_result_d, wb_read_data_d;
  logic [4:0]  wb_rd_addr_d;
  logic        wb_reg_write_d, wb_mem_to_reg_d;

  assign mem_op  = ma_mem_read_in | ma_mem_write_in;
  assign aligned = (ma_alu_result_in[1:0] == 2'b00);
  // A read with the write bit also set is a store.
  assign is_load = ma_mem_read_in & ~ma_mem_write_in;

  assign bus.dmem_addr  = ma_alu_result_in;
  assign bus.dmem_wdata = ma_write_data_in;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d       = state_q;
    mem_stall     = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    load_wb       = 1'b0;
    timeout       = 1'b0;
    fault         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            state_d   = ST_REQ;
            mem_stall = 1'b1;
          end else begin
            // Misaligned ops never reach the bus; they retire as a bubble.
            fault = 1'b1;
          end
        end else begin
          load_wb = 1'b1;
        end
      end

      ST_REQ: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = ma_mem_write_in;
        // rvalid is not looked at here: a same-cycle gnt+rvalid only grants.
        if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
          if (bus.dmem_gnt) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // A response on the final allowed cycle still completes the op.
        if (bus.dmem_rvalid) begin
          load_wb = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter is zero whenever the FSM sits in IDLE, so the first REQ cycle
  // always starts from 0.
  always_comb begin
    cnt_d = 10'd0;
    if ((state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  // ------------------------------------------------- MA/WB register next
  // Anything other than a retiring op (stall, fault, timeout) is a bubble.
  always_comb begin
    wb_pc_plus_4_d  = 32'd0;
    wb_alu_result_d = 32'd0;
    wb_read_data_d  = 32'd0;
    wb_rd_addr_d    = 5'd0;
    wb_reg_write_d  = 1'b0;
    wb_mem_to_reg_d = 1'b0;
    if (load_wb) begin
      wb_pc_plus_4_d  = ma_pc_plus_4_in;
      wb_alu_result_d = ma_alu_result_in;
      wb_rd_addr_d    = ma_rd_addr_in;
      wb_reg_write_d  = ma_reg_write_in;
      wb_mem_to_reg_d = ma_mem_to_reg_in;
      if ((state_q == ST_WAIT) && is_load) begin
        wb_read_data_d = bus.dmem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      cnt_q             <= 10'd0;
      wb_pc_plus_4_out  <= 32'd0;
      wb_alu_result_out <= 32'd0;
      wb_read_data_out  <= 32'd0;
      wb_rd_addr_out    <= 5'd0;
      wb_reg_write_out  <= 1'b0;
      wb_mem_to_reg_out <= 1'b0;
      misalign_fault    <= 1'b0;
      bus_err           <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      wb_pc_plus_4_out  <= wb_pc_plus_4_d;
      wb_alu_result_out <= wb_alu_result_d;
      wb_read_data_out  <= wb_read_data_d;
      wb_rd_addr_out    <= wb_rd_addr_d;
      wb_reg_write_out  <= wb_reg_write_d;
      wb_mem_to_reg_out <= wb_mem_to_reg_d;
      misalign_fault    <= fault;
      bus_err           <= timeout;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage (TIMEOUT_CYCLES = 8). Inputs change at
// posedge+1; combinational outputs are checked at posedge+2, registered
// outputs right after the edge that loads them.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ma_pc_plus_4_in, ma_alu_result_in, ma_write_data_in;
  logic [4:0]  ma_rd_addr_in;
  logic        ma_mem_read_in, ma_mem_write_in, ma_reg_write_in, ma_mem_to_reg_in;
  logic        mem_stall;
  logic [31:0] wb_pc_plus_4_out, wb_alu_result_out, wb_read_data_out;
  logic [4:0]  wb_rd_addr_out;
  logic        wb_reg_write_out, wb_mem_to_reg_out;
  logic        misalign_fault, bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .ma_pc_plus_4_in   (ma_pc_plus_4_in),
    .ma_alu_result_in  (ma_alu_result_in),
    .ma_write_data_in  (ma_write_data_in),
    .ma_rd_addr_in     (ma_rd_addr_in),
    .ma_mem_read_in    (ma_mem_read_in),
    .ma_mem_write_in   (ma_mem_write_in),
    .ma_reg_write_in   (ma_reg_write_in),
    .ma_mem_to_reg_in  (ma_mem_to_reg_in),
    .bus               (bus),
    .mem_stall         (mem_stall),
    .wb_pc_plus_4_out  (wb_pc_plus_4_out),
    .wb_alu_result_out (wb_alu_result_out),
    .wb_read_data_out  (wb_read_data_out),
    .wb_rd_addr_out    (wb_rd_addr_out),
    .wb_reg_write_out  (wb_reg_write_out),
    .wb_mem_to_reg_out (wb_mem_to_reg_out),
    .misalign_fault    (misalign_fault),
    .bus_err           (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rdm, input logic wrm,
                        input logic rw, input logic m2r);
    ma_pc_plus_4_in  = pc;
    ma_alu_result_in = alu;
    ma_write_data_in = wd;
    ma_rd_addr_in    = rd;
    ma_mem_read_in   = rdm;
    ma_mem_write_in  = wrm;
    ma_reg_write_in  = rw;
    ma_mem_to_reg_in = m2r;
  endtask

  task automatic nop();
    set_op(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_wb_rw"},  {31'd0, wb_reg_write_out},  32'd0);
    chk({tag, "_wb_m2r"}, {31'd0, wb_mem_to_reg_out}, 32'd0);
    chk({tag, "_wb_alu"}, wb_alu_result_out,          32'd0);
    chk({tag, "_wb_rd"},  {27'd0, wb_rd_addr_out},    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    nop();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'd0;

    // ---- reset state
    #2;
    chk("rst_req",   {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall},    32'd0);
    chk("rst_mf",    {31'd0, misalign_fault}, 32'd0);
    chk("rst_be",    {31'd0, bus_err},      32'd0);
    chk("rst_rdata", wb_read_data_out,      32'd0);
    chk_bubble("rst");
    $display("step reset checked");
    tick();
    rst = 1'b0;

    // ---- ALU op, single-cycle pass-through
    set_op(32'h4, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("alu_stall", {31'd0, mem_stall},    32'd0);
    chk("alu_req",   {31'd0, bus.dmem_req}, 32'd0);
    chk("alu_addr",  bus.dmem_addr,         32'h10);
    tick();
    chk("alu_wb_alu", wb_alu_result_out,          32'h10);
    chk("alu_wb_rd",  {27'd0, wb_rd_addr_out},    32'd5);
    chk("alu_wb_rw",  {31'd0, wb_reg_write_out},  32'd1);
    chk("alu_wb_pc",  wb_pc_plus_4_out,           32'h4);
    chk("alu_wb_rdd", wb_read_data_out,           32'd0);
    $display("step alu op checked");
    nop();

    // ---- asynchronous reset clears loaded wb outputs without a clock edge
    rst = 1'b1;
    #1;
    chk("arst_wb_alu", wb_alu_result_out,         32'd0);
    chk("arst_wb_rd",  {27'd0, wb_rd_addr_out},   32'd0);
    chk("arst_wb_rw",  {31'd0, wb_reg_write_out}, 32'd0);
    #1;
    rst = 1'b0;
    $display("step async reset checked");
    tick();

    // ---- load 0x100: gnt in cycle 2, rvalid in cycle 4
    set_op(32'h20, 32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("ld_c0_stall", {31'd0, mem_stall},    32'd1);
    chk("ld_c0_req",   {31'd0, bus.dmem_req}, 32'd0);
    tick();
    chk("ld_c1_stall", {31'd0, mem_stall},    32'd1);
    chk("ld_c1_req",   {31'd1 & 32'd0, bus.dmem_req} , 32'd1);
    chk("ld_c1_we",    {31'd0, bus.dmem_we},  32'd0);
    chk("ld_c1_addr",  bus.dmem_addr,         32'h100);
    chk_bubble("ld_c1");
    tick();
    bus.dmem_gnt = 1'b1;
    #1;
    chk("ld_c2_stall", {31'd0, mem_stall},    32'd1);
    chk("ld_c2_req",   {31'd0, bus.dmem_req}, 32'd1);
    tick();
    bus.dmem_gnt = 1'b0;
    #1;
    chk("ld_c3_stall", {31'd0, mem_stall},    32'd1);
    chk("ld_c3_req",   {31'd0, bus.dmem_req}, 32'd0);
    chk_bubble("ld_c3");
    tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hDEADBEEF;
    #1;
    chk("ld_c4_stall", {31'd0, mem_stall}, 32'd0);
    chk_bubble("ld_c4");
    tick();
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'd0;
    chk("ld_wb_rdd", wb_read_data_out,           32'hDEADBEEF);
    chk("ld_wb_m2r", {31'd0, wb_mem_to_reg_out}, 32'd1);
    chk("ld_wb_rw",  {31'd0, wb_reg_write_out},  32'd1);
    chk("ld_wb_rd",  {27'd0, wb_rd_addr_out},    32'd7);
    chk("ld_wb_alu", wb_alu_result_out,          32'h100);
    chk("ld_wb_pc",  wb_pc_plus_4_out,           32'h20);
    nop();
    #1;
    chk("ld_idle_stall", {31'd0, mem_stall},    32'd0);
    chk("ld_idle_req",   {31'd0, bus.dmem_req}, 32'd0);
    $display("step load 0x100 checked");
    tick();

    // ---- store 0x104; gnt and rvalid together in REQ only grants
    set_op(32'h30, 32'h104, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("st_c0_stall", {31'd0, mem_stall},    32'd1);
    chk("st_c0_we",    {31'd0, bus.dmem_we},  32'd0);
    tick();
    bus.dmem_gnt    = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h11111111;
    #1;
    chk("st_c1_req",   {31'd0, bus.dmem_req}, 32'd1);
    chk("st_c1_we",    {31'd0, bus.dmem_we},  32'd1);
    chk("st_c1_wdata", bus.dmem_wdata,        32'hA5A5A5A5);
    chk("st_c1_addr",  bus.dmem_addr,         32'h104);
    chk("st_c1_stall", {31'd0, mem_stall},    32'd1);
    tick();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    #1;
    chk("st_c2_req",   {31'd0, bus.dmem_req}, 32'd0);
    chk("st_c2_we",    {31'd0, bus.dmem_we},  32'd0);
    chk("st_c2_stall", {31'd0, mem_stall},    32'd1);
    chk_bubble("st_c2");
    tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h12345678;
    #1;
    chk("st_c3_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'd0;
    chk("st_wb_rdd", wb_read_data_out,          32'd0);
    chk("st_wb_rw",  {31'd0, wb_reg_write_out}, 32'd0);
    chk("st_wb_alu", wb_alu_result_out,         32'h104);
    chk("st_wb_pc",  wb_pc_plus_4_out,          32'h30);
    nop();
    $display("step store 0x104 checked");
    tick();

    // ---- misaligned load 0x102
    set_op(32'h40, 32'h102, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("mis_stall", {31'd0, mem_stall},    32'd0);
    chk("mis_req",   {31'd0, bus.dmem_req}, 32'd0);
    tick();
    chk("mis_mf", {31'd1 & 32'd0, misalign_fault}, 32'd1);
    chk_bubble("mis");
    nop();
    #1;
    chk("mis_req2", {31'd0, bus.dmem_req}, 32'd0);
    tick();
    chk("mis_mf_end", {31'd0, misalign_fault}, 32'd0);
    $display("step misaligned load checked");

    // ---- timeout: gnt never comes, 8 cycles in REQ
    set_op(32'h50, 32'h200, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("to_c0_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("to_c%0d_stall", i), {31'd0, mem_stall},    32'd1);
      chk($sformatf("to_c%0d_req", i),   {31'd0, bus.dmem_req}, 32'd1);
      chk($sformatf("to_c%0d_be", i),    {31'd0, bus_err},      32'd0);
      tick();
    end
    chk("to_c8_stall", {31'd0, mem_stall},    32'd0);
    chk("to_c8_req",   {31'd0, bus.dmem_req}, 32'd1);
    tick();
    chk("to_be", {31'd0, bus_err}, 32'd1);
    chk_bubble("to");
    nop();
    #1;
    chk("to_idle_req",   {31'd0, bus.dmem_req}, 32'd0);
    chk("to_idle_stall", {31'd0, mem_stall},    32'd0);
    tick();
    chk("to_be_end", {31'd0, bus_err}, 32'd0);
    $display("step timeout checked");

    // ---- reset while in WAIT, late rvalid ignored
    set_op(32'h60, 32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    #1;
    chk("rw_pre_stall", {31'd0, mem_stall},    32'd1);
    chk("rw_pre_req",   {31'd0, bus.dmem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rw_rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk_bubble("rw_rst");
    #1;
    rst = 1'b0;
    nop();
    #1;
    chk("rw_idle_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hCAFEF00D;
    #1;
    chk("rw_rv_stall", {31'd0, mem_stall},    32'd0);
    chk("rw_rv_req",   {31'd0, bus.dmem_req}, 32'd0);
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("rw_wb_rdd", wb_read_data_out,           32'd0);
    chk("rw_wb_m2r", {31'd0, wb_mem_to_reg_out}, 32'd0);
    chk("rw_wb_rd",  {27'd0, wb_rd_addr_out},    32'd0);
    $display("step reset in wait checked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
